bcd_seq_ctrl: RTL and testbench
===============================

# bcd_seq_ctrl

Sequential, handshake-driven binary-to-BCD converter for 9-bit unsigned inputs (0..511). It splits the conversion into nine shift-and-add-3 (double-dabble) steps. A small FSM and an iteration counter sequence those steps over one shared digit-correction datapath. It is the clocked replacement for the combinational BCD block and is driven by a PATTERN-style bench through an `in_valid`/`out_valid` handshake.

## Interface
- `IN_W`, default 9: binary input width. Fixed at 9 in this release.
- `ITER`, default 9: number of shift iterations. Must equal `IN_W`.
- Reset is asynchronous and active-low.
- `clk`  input  1  rising-edge clock; the single clock domain.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  one-cycle pulse that qualifies `in_bin`.
- `in_bin`  input  9  unsigned binary value, 0..511.
- `busy`  output  1  high while a conversion is in progress (state SHIFT).
- `out_valid`  output  1  one-cycle pulse; the digits are valid in this cycle.
- `out_hundred`  output  3  hundreds digit, 0..5.
- `out_ten`  output  4  tens digit, 0..9.
- `out_unit`  output  4  units digit, 0..9.

## Operation
- States:
  - IDLE: waiting for input.
  - SHIFT: conversion iterations in progress.
  - DONE: result presented for one cycle.
- Internal registers:
  - `bin_q[8:0]`: shift register holding the remaining binary bits.
  - `bcd_q[10:0]`: packed hundreds[10:8], tens[7:4], units[3:0].
  - `cnt[3:0]`: iteration counter.
- IDLE or DONE with `in_valid`=1:
  - `bin_q` <= `in_bin`, `bcd_q` <= 0, `cnt` <= 0.
  - Next state is SHIFT.
- IDLE with `in_valid`=0: stay in IDLE.
- DONE with `in_valid`=0: go to IDLE.
- SHIFT, each cycle:
  - Correct the digits: if units >= 5, add 3; if tens >= 5, add 3. The two checks are independent and use the pre-correction values.
  - Shift the corrected `{bcd, bin_q}` left by one bit.
  - `cnt` <= `cnt`+1.
- SHIFT exit: when `cnt`==8, that shift is the last one. Next state is DONE, and the shifted digits are loaded into the output registers.
- Hundreds needs no correction. It is at most 2 before the final shift, so no add-3 logic is built for it.
- `in_valid` while `busy`=1 is ignored. It is dropped, not queued, and does not disturb the running conversion.
- Outputs:
  - `out_hundred`, `out_ten`, `out_unit` are registered.
  - They are nonzero only while `out_valid`=1 and are forced to 0 in every other cycle.
- `busy` is 1 exactly when state is SHIFT.
- Asynchronous reset, including mid-conversion:
  - State goes to IDLE; `cnt` and all shift and data registers go to 0.
  - `busy`=0 and `out_valid`=0. The partial result is discarded and no `out_valid` is produced for it.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_hundred`=0, `out_ten`=0, `out_unit`=0.
- Latency, for `in_valid` sampled at rising edge k:
  - Edge k: load.
  - Edges k+1..k+9: the nine shifts.
  - `out_valid`=1 from edge k+9 to edge k+10, exactly one cycle.
  - Total: 9 cycles from the sampling edge to `out_valid` rising.
- `busy`=1 from edge k to edge k+9.
- Throughput: a new `in_valid` may be sampled at edge k+9 (the cycle after the last SHIFT cycle, while `out_valid` is high). Its result arrives at edge k+18. Maximum rate is one conversion per 9 cycles.
- The earliest `in_valid` accepted after reset release is at the first rising edge with `rst_n`=1.
- The first edge with `rst_n`=1 after a mid-operation reset behaves as IDLE.

## Test plan
- Reset, then `in_bin`=0 -> `out_valid` exactly 9 cycles after the sampling edge, with digits 0/0/0; all outputs 0 in every other cycle.
- Input sweep -> `out_valid` 9 cycles after each sampling edge, with these digits:
  - `in_bin`=511 -> 5/1/1.
  - 255 -> 2/5/5.
  - 99 -> 0/9/9.
  - 100 -> 1/0/0.
- `in_valid` asserted again exactly on the `out_valid` cycle of the previous conversion (first 123, then 456) -> two `out_valid` pulses 9 cycles apart, 1/2/3 then 4/5/6.
- `in_valid` with `in_bin`=200, then `in_valid` with 7 three cycles later (while `busy`) -> a single `out_valid` carrying 2/0/0; the second request produces no pulse.
- Drop `rst_n` at cycle 4 of converting 345 -> `busy` and all outputs go to 0 immediately. After release, no `out_valid` appears within 20 cycles; a new request with 42 then returns 0/4/2.
- Exhaustive 0..511, each applied after the previous `out_valid` -> every result matches the reference digits, with latency always 9 cycles.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// Sequential 9-bit binary-to-BCD converter: one shift-and-add-3 step per clock
// over a shared correction datapath, sequenced by a small FSM and counter.
module bcd_seq_ctrl #(
  parameter int IN_W = 9,
  parameter int ITER = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_bin,
  output logic            busy,
  output logic            out_valid,
  output logic [2:0]      out_hundred,
  output logic [3:0]      out_ten,
  output logic [3:0]      out_unit
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LAST    = 4'(ITER - 1);

  logic [1:0]      state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [10:0]     bcd_q, bcd_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [2:0]      hun_q, hun_d;
  logic [3:0]      ten_q, ten_d;
  logic [3:0]      unit_q, unit_d;

  logic [3:0]           units_c, tens_c;
  logic [IN_W+10:0]     step_in, step_out;

  // Hundreds is at most 2 before the final shift, so only tens/units get add-3.
  always_comb begin
    units_c  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_c   = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    step_in  = {bcd_q[10:8], tens_c, units_c, bin_q};
    step_out = step_in << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    hun_d   = 3'd0;
    ten_d   = 4'd0;
    unit_d  = 4'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        bcd_d = step_out[IN_W+10:IN_W];
        bin_d = step_out[IN_W-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          hun_d   = step_out[IN_W+10:IN_W+8];
          ten_d   = step_out[IN_W+7:IN_W+4];
          unit_d  = step_out[IN_W+3:IN_W];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hun_q   <= '0;
      ten_q   <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      unit_q  <= unit_d;
    end
  end

  assign busy        = (state_q == S_SHIFT);
  assign out_valid   = valid_q;
  assign out_hundred = hun_q;
  assign out_ten     = ten_q;
  assign out_unit    = unit_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: directed vector table, corner-case
// sequences and an exhaustive sweep, all checked through a latency-aware scoreboard.
module tb_bcd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_bin = '0;
  logic       busy, out_valid;
  logic [2:0] out_hundred;
  logic [3:0] out_ten, out_unit;

  bcd_seq_ctrl #(.IN_W(9), .ITER(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bin(in_bin),
    .busy(busy), .out_valid(out_valid), .out_hundred(out_hundred),
    .out_ten(out_ten), .out_unit(out_unit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] bin;
    logic [2:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } vec_t;

  typedef struct {
    int bin;
    int h;
    int t;
    int u;
    int due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Reference digits from plain integer arithmetic.
  function automatic exp_t model(input int v, input int due);
    exp_t e;
    e.bin = v;
    e.h   = v / 100;
    e.t   = (v / 10) % 10;
    e.u   = v % 10;
    e.due = due;
    return e;
  endfunction

  // Monitor: every out_valid must match the head of the scoreboard on time;
  // in every other cycle the digits must be zero.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid cyc=%0d got=%0d/%0d/%0d expected=none",
                 cyc, out_hundred, out_ten, out_unit);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("[TB] result bin=%0d got=%0d/%0d/%0d expected=%0d/%0d/%0d cyc=%0d due=%0d",
                 e.bin, out_hundred, out_ten, out_unit, e.h, e.t, e.u, cyc, e.due);
        check("hundred", int'(out_hundred), e.h);
        check("ten", int'(out_ten), e.t);
        check("unit", int'(out_unit), e.u);
        check("latency", cyc, e.due);
        check("busy_in_done", int'(busy), 0);
      end
    end else begin
      check("idle_digits_zero", int'({out_hundred, out_ten, out_unit}), 0);
      if (q.size() != 0 && cyc >= q[0].due) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_valid bin=%0d cyc=%0d got=no_pulse expected=pulse_at_%0d",
                 e.bin, cyc, e.due);
      end
    end
  end

  // Drive a request in the current (low) phase; it is sampled at the next edge.
  task automatic drive_now(input int v, input bit accept);
    in_valid = 1'b1;
    in_bin   = 9'(v);
    if (accept) q.push_back(model(v, cyc + 10));
    $display("[TB] request bin=%0d accept=%0d cyc=%0d", v, accept, cyc);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_request", int'(busy), 1);
  endtask

  task automatic send(input int v, input bit accept);
    @(negedge clk);
    drive_now(v, accept);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{bin: 9'd0,   h: 3'd0, t: 4'd0, u: 4'd0};
    vecs[1] = '{bin: 9'd511, h: 3'd5, t: 4'd1, u: 4'd1};
    vecs[2] = '{bin: 9'd255, h: 3'd2, t: 4'd5, u: 4'd5};
    vecs[3] = '{bin: 9'd99,  h: 3'd0, t: 4'd9, u: 4'd9};
    vecs[4] = '{bin: 9'd100, h: 3'd1, t: 4'd0, u: 4'd0};

    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_digits", int'({out_hundred, out_ten, out_unit}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, expectations taken from the table itself.
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_bin   = vecs[i].bin;
      e.bin = int'(vecs[i].bin);
      e.h   = int'(vecs[i].h);
      e.t   = int'(vecs[i].t);
      e.u   = int'(vecs[i].u);
      e.due = cyc + 10;
      q.push_back(e);
      $display("[TB] request bin=%0d accept=1 cyc=%0d", vecs[i].bin, cyc);
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_request", int'(busy), 1);
      drain(20);
    end

    // Back-to-back: second request raised during the first out_valid cycle.
    send(123, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_pulse_seen", int'(out_valid), 1);
    end
    drive_now(456, 1'b1);
    drain(20);

    // Request while busy is dropped.
    send(200, 1'b1);
    repeat (2) @(negedge clk);
    drive_now(7, 1'b0);
    drain(20);
    repeat (15) @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    send(345, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_digits", int'({out_hundred, out_ten, out_unit}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(42, 1'b1);
    drain(20);

    // Exhaustive sweep against the arithmetic model.
    for (int v = 0; v < 512; v++) begin
      send(v, 1'b1);
      drain(20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
